uart_apb_regs_fifo: RTL and testbench
=====================================

Name: uart_apb_regs_fifo

Overview:
APB3 slave register file for the UART, parametrised successor of the single-byte register block. It adds parametrised TX/RX FIFOs behind the DR register, trigger-level RX interrupts, a prioritised interrupt identification register, sticky line-status flags and a fixed one-wait-state APB handshake. It sits between the APB fabric and the UART TX/RX shift-register core.

Parameters:
APB_DATA_WIDTH, 32, APB data width (>=32)
APB_ADDR_WIDTH, 32, APB address width
UART_REG_BASE, 32'ha0300000, base address; addr[AW-1:8] must match
FIFO_DEPTH, 16, TX and RX FIFO depth; power of two, >=4
DLR_RESET, 16'd0, divisor latch reset value

Ports:
apb_clk_in  in  1  APB clock
apb_rstn_in  in  1  async active-low reset
apb_addr_in  in  APB_ADDR_WIDTH  address
apb_psel_in  in  1  select
apb_penable_in  in  1  enable
apb_write_in  in  1  1=write
apb_wdata_in  in  APB_DATA_WIDTH  write data
apb_rdata_out  out  APB_DATA_WIDTH  read data, valid with ready
apb_ready_out  out  1  PREADY
apb_slverr_out  out  1  PSLVERR, valid with ready
tx_data_out  out  8  TX FIFO head byte
tx_valid_out  out  1  TX FIFO non-empty
tx_ready_in  in  1  core pops TX head when valid&ready
tx_idle_in  in  1  TX shifter idle
rx_data_in  in  8  received byte
rx_valid_in  in  1  push strobe, one cycle per byte
rx_pe_in / rx_fe_in / rx_bi_in  in  1 each  error flags qualified by rx_valid_in
lcr_out  out  7  {BC,SP,EPS,PEN,STB,WLS[1:0]}
dlr_out  out  16  divisor latch
irq_out  out  1  interrupt, registered

Behaviour:
- Reset (apb_rstn_in, asynchronous, active-low; clock apb_clk_in): all outputs 0 except dlr_out=DLR_RESET; FIFOs empty; IER/LCR/FCR/sticky flags 0. Reset mid-transfer aborts it; no ready is issued.
- APB: setup (psel&!penable) then access. apb_ready_out rises exactly one cycle after the first access cycle, is held for one cycle, then returns to 0. Register side effects occur only on the ready cycle. Error (slverr=1): base mismatch, offset>0x1C, addr[1:0]!=0, write to RO register, DR write with TX full (byte dropped). An error transfer has no side effect. rdata=0 on writes and errors.
- Map (offset, bits):
  - 0x00 DR: write pushes wdata[7:0]; read pops RX head; RX empty returns 0, no error.
  - 0x04 IER RW [0]ERBI [1]ETBEI [2]ELSI.
  - 0x08 IIR RO [0]IPEND (1=none) [3:1]INTID.
  - 0x0C LCR RW [6:0].
  - 0x10 FCR RW [0]FIFOEN [1]RXCLR [2]TXCLR [7:6]RXFIFTL; RXCLR/TXCLR self-clear, read 0.
  - 0x14 LSR RO [0]DR=rx non-empty, [1]OE [2]PE [3]FE [4]BI sticky, cleared by LSR read; [5]THRE=tx empty; [6]TEMT=THRE&tx_idle_in.
  - 0x18 DLR RW [15:0].
  - 0x1C STAT RO [15:0]rx_count, [31:16]tx_count.
- FIFOEN=0: effective depth 1 for both FIFOs. Toggling FIFOEN flushes both.
- RX trigger: RXFIFTL 0/1/2/3 -> 1, DEPTH/4, DEPTH/2, DEPTH-2.
- RX push while full: byte dropped, OE set; PE/FE/BI set on the push of a flagged byte.
- Simultaneous events:
  - Push and pop in the same cycle (including when full): both occur, count unchanged.
  - RXCLR coinciding with rx push: flush wins, byte dropped.
  - TXCLR coinciding with tx pop: flush wins.
  - Sticky set and LSR-read clear in the same cycle: set wins.
- THRE interrupt latch sets on the TX non-empty->empty transition (and at reset). It clears on IIR read or DR write.
- Priority: LS (ELSI & any OE|PE|FE|BI) INTID=011 > RDA (ERBI & rx_count>=trigger) 010 > THRE (ETBEI & latch) 001 > none (IPEND=1, INTID=000). irq_out = registered !IPEND, one cycle latency.
- Counts are $clog2(FIFO_DEPTH)+1 bits, zero-extended; pointers wrap modulo DEPTH.

Decomposition:
- Package uart_regs_pkg: register offsets, MAX_OFFSET, bit positions, INTID codes, trigger-level decode function.
- Sub-module uart_sync_fifo (WIDTH, DEPTH, depth_one mode, flush, push, pop, count, full, empty), instantiated for TX and RX.
- APB FSM, decode and interrupt logic live in the top.

Test Plan:
- Write LCR 0x1B, DLR 0x0145, read back -> rdata 0x1B, 0x0145; lcr_out=7'h1B, dlr_out=16'h0145; each ready exactly one cycle after first access cycle.
- FIFOEN=1, 17 DR writes with tx_ready_in=0 -> first 16 ok, 17th slverr=1; STAT[31:16]=16; then tx_ready_in=1 drains in written order, THRE set, irq with ETBEI=1, INTID=001.
- RXFIFTL=2, ERBI=1, push 8 bytes -> irq_out rises the cycle after the 8th push, IIR=0x04; read DR x8 returns bytes in order, irq clears.
- Fill RX (16), push once more with rx_pe_in=1 -> OE=1, PE=0, IIR INTID=011 overrides RDA; LSR read returns OE set, next LSR read OE=0.
- Address 0xa0300020, 0xa0400000, 0xa0300006, write to 0x14 -> slverr=1, no state change; reset asserted during access phase -> ready stays 0, all registers at reset values.

Source files
------------

// File: rtl/uart_regs_pkg.sv
// Shared definitions for the UART APB register block: register map, field
// positions, interrupt identification codes and the RX trigger-level decode.
package uart_regs_pkg;

  localparam logic [7:0] OFF_DR     = 8'h00;
  localparam logic [7:0] OFF_IER    = 8'h04;
  localparam logic [7:0] OFF_IIR    = 8'h08;
  localparam logic [7:0] OFF_LCR    = 8'h0C;
  localparam logic [7:0] OFF_FCR    = 8'h10;
  localparam logic [7:0] OFF_LSR    = 8'h14;
  localparam logic [7:0] OFF_DLR    = 8'h18;
  localparam logic [7:0] OFF_STAT   = 8'h1C;
  localparam logic [7:0] MAX_OFFSET = 8'h1C;

  localparam int IER_ERBI  = 0;
  localparam int IER_ETBEI = 1;
  localparam int IER_ELSI  = 2;

  localparam int FCR_FIFOEN = 0;
  localparam int FCR_RXCLR  = 1;
  localparam int FCR_TXCLR  = 2;

  localparam logic [2:0] INTID_NONE = 3'b000;
  localparam logic [2:0] INTID_THRE = 3'b001;
  localparam logic [2:0] INTID_RDA  = 3'b010;
  localparam logic [2:0] INTID_LS   = 3'b011;

  typedef enum logic [0:0] {
    APB_IDLE = 1'b0,
    APB_RESP = 1'b1
  } apb_state_e;

  // With the FIFOs disabled the receiver holds a single byte, so any byte triggers.
  function automatic int rx_trigger_level(input logic fifo_en, input logic [1:0] sel,
                                          input int depth);
    if (!fifo_en) return 1;
    case (sel)
      2'd0:    return 1;
      2'd1:    return depth / 4;
      2'd2:    return depth / 2;
      default: return depth - 2;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with flush and a single-entry mode; push and pop may
// coincide even when full, and flush overrides both.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             apb_clk_in,
  input  logic             apb_rstn_in,
  input  logic             depth_one,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_en;
  logic             pop_en;

  assign empty   = (count == '0);
  assign full    = depth_one ? (count != '0) : (count == CW'(DEPTH));
  assign pop_en  = pop && !empty;
  assign push_en = push && (!full || pop_en);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge apb_clk_in) begin
    if (push_en && !flush) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_apb_regs_fifo.sv
// APB3 register file for the UART: TX/RX FIFOs behind DR, line status,
// prioritised interrupt identification and a fixed one-wait-state handshake.
module uart_apb_regs_fifo #(
  parameter int                        APB_DATA_WIDTH = 32,
  parameter int                        APB_ADDR_WIDTH = 32,
  parameter logic [APB_ADDR_WIDTH-1:0] UART_REG_BASE  = 32'ha0300000,
  parameter int                        FIFO_DEPTH     = 16,
  parameter logic [15:0]               DLR_RESET      = 16'd0
) (
  input  logic                      apb_clk_in,
  input  logic                      apb_rstn_in,
  input  logic [APB_ADDR_WIDTH-1:0] apb_addr_in,
  input  logic                      apb_psel_in,
  input  logic                      apb_penable_in,
  input  logic                      apb_write_in,
  input  logic [APB_DATA_WIDTH-1:0] apb_wdata_in,
  output logic [APB_DATA_WIDTH-1:0] apb_rdata_out,
  output logic                      apb_ready_out,
  output logic                      apb_slverr_out,
  output logic [7:0]                tx_data_out,
  output logic                      tx_valid_out,
  input  logic                      tx_ready_in,
  input  logic                      tx_idle_in,
  input  logic [7:0]                rx_data_in,
  input  logic                      rx_valid_in,
  input  logic                      rx_pe_in,
  input  logic                      rx_fe_in,
  input  logic                      rx_bi_in,
  output logic [6:0]                lcr_out,
  output logic [15:0]               dlr_out,
  output logic                      irq_out
);
  import uart_regs_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Handshakes: an APB transfer completes on the single cycle apb_ready_out is
  // high (rdata/slverr valid only then); the core takes the TX head on any
  // cycle where tx_valid_out & tx_ready_in; rx_valid_in is a one-cycle push.
  apb_state_e apb_state, apb_state_nxt;

  logic [2:0]  ier;
  logic [6:0]  lcr;
  logic        fifoen;
  logic [1:0]  rxfiftl;
  logic [15:0] dlr;
  logic [3:0]  lsr_err;
  logic        thre_latch;
  logic        tx_empty_q;
  logic        irq_q;

  logic [7:0]    tx_head, rx_head;
  logic [CW-1:0] tx_count, rx_count;
  logic          tx_full, tx_empty, rx_full, rx_empty;

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) apb_state <= APB_IDLE;
    else              apb_state <= apb_state_nxt;
  end

  always_comb begin
    apb_state_nxt = apb_state;
    apb_ready_out = 1'b0;
    case (apb_state)
      APB_IDLE: if (apb_psel_in && apb_penable_in) apb_state_nxt = APB_RESP;
      APB_RESP: begin
        apb_ready_out = 1'b1;
        apb_state_nxt = APB_IDLE;
      end
      default: apb_state_nxt = APB_IDLE;
    endcase
  end

  logic [7:0] off;
  logic       base_ok, ro_off, xfer_err, fire, wr_fire, rd_fire;

  assign off      = apb_addr_in[7:0];
  assign base_ok  = (apb_addr_in[APB_ADDR_WIDTH-1:8] == UART_REG_BASE[APB_ADDR_WIDTH-1:8]);
  assign ro_off   = (off == OFF_IIR) || (off == OFF_LSR) || (off == OFF_STAT);
  assign xfer_err = !base_ok || (off > MAX_OFFSET) || (off[1:0] != 2'b00) ||
                    (apb_write_in && ro_off) ||
                    (apb_write_in && (off == OFF_DR) && tx_full);
  assign fire     = apb_ready_out && !xfer_err;
  assign wr_fire  = fire && apb_write_in;
  assign rd_fire  = fire && !apb_write_in;

  logic dr_wr, dr_rd, ier_wr, lcr_wr, fcr_wr, dlr_wr, iir_rd, lsr_rd;
  assign dr_wr  = wr_fire && (off == OFF_DR);
  assign ier_wr = wr_fire && (off == OFF_IER);
  assign lcr_wr = wr_fire && (off == OFF_LCR);
  assign fcr_wr = wr_fire && (off == OFF_FCR);
  assign dlr_wr = wr_fire && (off == OFF_DLR);
  assign dr_rd  = rd_fire && (off == OFF_DR);
  assign iir_rd = rd_fire && (off == OFF_IIR);
  assign lsr_rd = rd_fire && (off == OFF_LSR);

  // Changing FIFOEN empties both FIFOs so no byte straddles the depth change.
  logic flush_both, tx_flush, rx_flush, tx_pop, rx_pop_ok, rx_accept, rx_overrun;
  logic [3:0] lsr_set;
  assign flush_both = fcr_wr && (apb_wdata_in[FCR_FIFOEN] != fifoen);
  assign tx_flush   = flush_both || (fcr_wr && apb_wdata_in[FCR_TXCLR]);
  assign rx_flush   = flush_both || (fcr_wr && apb_wdata_in[FCR_RXCLR]);
  assign tx_pop     = !tx_empty && tx_ready_in;
  assign rx_pop_ok  = dr_rd && !rx_empty;
  assign rx_accept  = rx_valid_in && !rx_flush && (!rx_full || rx_pop_ok);
  assign rx_overrun = rx_valid_in && !rx_flush && rx_full && !rx_pop_ok;
  assign lsr_set    = {rx_bi_in && rx_accept, rx_fe_in && rx_accept,
                       rx_pe_in && rx_accept, rx_overrun};

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .apb_clk_in (apb_clk_in),
    .apb_rstn_in(apb_rstn_in),
    .depth_one  (!fifoen),
    .flush      (tx_flush),
    .push       (dr_wr),
    .wr_data    (apb_wdata_in[7:0]),
    .pop        (tx_pop),
    .rd_data    (tx_head),
    .count      (tx_count),
    .full       (tx_full),
    .empty      (tx_empty)
  );

  uart_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .apb_clk_in (apb_clk_in),
    .apb_rstn_in(apb_rstn_in),
    .depth_one  (!fifoen),
    .flush      (rx_flush),
    .push       (rx_valid_in),
    .wr_data    (rx_data_in),
    .pop        (dr_rd),
    .rd_data    (rx_head),
    .count      (rx_count),
    .full       (rx_full),
    .empty      (rx_empty)
  );

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      ier        <= '0;
      lcr        <= '0;
      fifoen     <= 1'b0;
      rxfiftl    <= '0;
      dlr        <= DLR_RESET;
      lsr_err    <= '0;
      thre_latch <= 1'b1;
      tx_empty_q <= 1'b1;
    end else begin
      if (ier_wr) ier <= apb_wdata_in[2:0];
      if (lcr_wr) lcr <= apb_wdata_in[6:0];
      if (dlr_wr) dlr <= apb_wdata_in[15:0];
      if (fcr_wr) begin
        fifoen  <= apb_wdata_in[FCR_FIFOEN];
        rxfiftl <= apb_wdata_in[7:6];
      end
      lsr_err    <= (lsr_err & ~{4{lsr_rd}}) | lsr_set;
      tx_empty_q <= tx_empty;
      if (tx_empty && !tx_empty_q) thre_latch <= 1'b1;
      else if (iir_rd || dr_wr)    thre_latch <= 1'b0;
    end
  end

  logic [CW-1:0] rx_trig;
  logic [2:0]    intid;
  logic          ipend;
  assign rx_trig = CW'(rx_trigger_level(fifoen, rxfiftl, FIFO_DEPTH));

  always_comb begin
    intid = INTID_NONE;
    ipend = 1'b1;
    if (ier[IER_ELSI] && (lsr_err != '0)) begin
      intid = INTID_LS;
      ipend = 1'b0;
    end else if (ier[IER_ERBI] && (rx_count >= rx_trig)) begin
      intid = INTID_RDA;
      ipend = 1'b0;
    end else if (ier[IER_ETBEI] && thre_latch) begin
      intid = INTID_THRE;
      ipend = 1'b0;
    end
  end

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) irq_q <= 1'b0;
    else              irq_q <= !ipend;
  end

  logic [31:0] rd_val;
  always_comb begin
    rd_val = 32'h0;
    case (off)
      OFF_DR:   rd_val = {24'h0, rx_head};
      OFF_IER:  rd_val = {29'h0, ier};
      OFF_IIR:  rd_val = {28'h0, intid, ipend};
      OFF_LCR:  rd_val = {25'h0, lcr};
      OFF_FCR:  rd_val = {24'h0, rxfiftl, 5'b0, fifoen};
      OFF_LSR:  rd_val = {25'h0, tx_empty && tx_idle_in, tx_empty, lsr_err, !rx_empty};
      OFF_DLR:  rd_val = {16'h0, dlr};
      OFF_STAT: rd_val = {16'(tx_count), 16'(rx_count)};
      default:  rd_val = 32'h0;
    endcase
  end

  assign apb_rdata_out  = (apb_ready_out && !apb_write_in && !xfer_err) ?
                          APB_DATA_WIDTH'(rd_val) : '0;
  assign apb_slverr_out = apb_ready_out && xfer_err;
  assign tx_data_out    = tx_head;
  assign tx_valid_out   = !tx_empty;
  assign lcr_out        = lcr;
  assign dlr_out        = dlr;
  assign irq_out        = irq_q;

  logic unused_wdata;
  assign unused_wdata = ^apb_wdata_in[APB_DATA_WIDTH-1:16];

endmodule

// File: tb/tb_uart_apb_regs_fifo.sv
// Directed bench for uart_apb_regs_fifo: vector tables of APB transfers plus
// hand sequences for FIFO fill/drain, interrupts, overrun and reset abort.
module tb_uart_apb_regs_fifo;

  localparam logic [31:0] BASE   = 32'ha0300000;
  localparam logic [31:0] A_DR   = BASE + 32'h00;
  localparam logic [31:0] A_IER  = BASE + 32'h04;
  localparam logic [31:0] A_IIR  = BASE + 32'h08;
  localparam logic [31:0] A_LCR  = BASE + 32'h0C;
  localparam logic [31:0] A_FCR  = BASE + 32'h10;
  localparam logic [31:0] A_LSR  = BASE + 32'h14;
  localparam logic [31:0] A_DLR  = BASE + 32'h18;
  localparam logic [31:0] A_STAT = BASE + 32'h1C;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] paddr, pwdata, prdata;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [7:0]  tx_data, rx_data;
  logic        tx_valid, tx_ready, tx_idle;
  logic        rx_valid, rx_pe, rx_fe, rx_bi;
  logic [6:0]  lcr;
  logic [15:0] dlr;
  logic        irq;

  uart_apb_regs_fifo dut (
    .apb_clk_in    (clk),
    .apb_rstn_in   (rstn),
    .apb_addr_in   (paddr),
    .apb_psel_in   (psel),
    .apb_penable_in(penable),
    .apb_write_in  (pwrite),
    .apb_wdata_in  (pwdata),
    .apb_rdata_out (prdata),
    .apb_ready_out (pready),
    .apb_slverr_out(pslverr),
    .tx_data_out   (tx_data),
    .tx_valid_out  (tx_valid),
    .tx_ready_in   (tx_ready),
    .tx_idle_in    (tx_idle),
    .rx_data_in    (rx_data),
    .rx_valid_in   (rx_valid),
    .rx_pe_in      (rx_pe),
    .rx_fe_in      (rx_fe),
    .rx_bi_in      (rx_bi),
    .lcr_out       (lcr),
    .dlr_out       (dlr),
    .irq_out       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vt[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // lat counts cycles from the first access cycle to the ready cycle.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    lat = 0;
    @(negedge clk);
    while (!pready && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    rdata = prdata;
    err   = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic run_table(input string tag);
    logic [31:0] rd;
    logic        er;
    int          lat;
    foreach (vt[i]) begin
      apb_xfer(vt[i].wr, vt[i].addr, vt[i].wdata, rd, er, lat);
      chk($sformatf("%s[%0d].rdata", tag, i), rd, vt[i].exp_rdata);
      chk($sformatf("%s[%0d].slverr", tag, i), {31'b0, er}, {31'b0, vt[i].exp_err});
      chk($sformatf("%s[%0d].latency", tag, i), lat, 1);
    end
    vt.delete();
  endtask

  task automatic rx_push(input logic [7:0] d, input logic pe);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = d; rx_pe = pe;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_pe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    tx_ready = 1'b0; tx_idle = 1'b1; rx_valid = 1'b0; rx_data = '0;
    rx_pe = 1'b0; rx_fe = 1'b0; rx_bi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.ready", {31'b0, pready}, 0);
    chk("rst.outs", {irq, tx_valid, pslverr, tx_data, lcr}, 0);
    chk("rst.dlr", {16'h0, dlr}, 0);
    chk("rst.rdata", prdata, 0);
    @(posedge clk); #1 rstn = 1'b1;

    // Basic register access and error decode
    vt.push_back(vec_t'{1'b1, A_LCR, 32'h1B, 32'h0, 1'b0});
    vt.push_back(vec_t'{1'b1, A_DLR, 32'h0145, 32'h0, 1'b0});
    vt.push_back(vec_t'{1'b0, A_LCR, 32'h0, 32'h1B, 1'b0});
    vt.push_back(vec_t'{1'b0, A_DLR, 32'h0, 32'h0145, 1'b0});
    vt.push_back(vec_t'{1'b0, A_IIR, 32'h0, 32'h01, 1'b0});
    vt.push_back(vec_t'{1'b0, A_LSR, 32'h0, 32'h60, 1'b0});
    vt.push_back(vec_t'{1'b0, A_IER, 32'h0, 32'h0, 1'b0});
    vt.push_back(vec_t'{1'b0, A_FCR, 32'h0, 32'h0, 1'b0});
    vt.push_back(vec_t'{1'b0, BASE + 32'h20, 32'h0, 32'h0, 1'b1});
    vt.push_back(vec_t'{1'b1, 32'ha0400000, 32'h77, 32'h0, 1'b1});
    vt.push_back(vec_t'{1'b0, BASE + 32'h06, 32'h0, 32'h0, 1'b1});
    vt.push_back(vec_t'{1'b1, A_LSR, 32'hFF, 32'h0, 1'b1});
    vt.push_back(vec_t'{1'b1, A_IIR, 32'hFF, 32'h0, 1'b1});
    vt.push_back(vec_t'{1'b1, A_STAT, 32'hFF, 32'h0, 1'b1});
    vt.push_back(vec_t'{1'b1, 32'ha0400000 + 32'h0C, 32'h7F, 32'h0, 1'b1});
    vt.push_back(vec_t'{1'b0, A_LCR, 32'h0, 32'h1B, 1'b0});
    vt.push_back(vec_t'{1'b0, A_STAT, 32'h0, 32'h0, 1'b0});
    vt.push_back(vec_t'{1'b0, A_DR, 32'h0, 32'h0, 1'b0});
    run_table("regs");
    @(negedge clk);
    chk("lcr_out", {25'b0, lcr}, 32'h1B);
    chk("dlr_out", {16'b0, dlr}, 32'h0145);
    chk("ready_drops", {31'b0, pready}, 0);

    // TX FIFO fill to overflow, then drain
    vt.push_back(vec_t'{1'b1, A_FCR, 32'h01, 32'h0, 1'b0});
    for (int i = 0; i < 17; i++)
      vt.push_back(vec_t'{1'b1, A_DR, 32'h10 + i, 32'h0, (i == 16)});
    vt.push_back(vec_t'{1'b0, A_STAT, 32'h0, 32'h0010_0000, 1'b0});
    vt.push_back(vec_t'{1'b0, A_LSR, 32'h0, 32'h00, 1'b0});
    run_table("txfill");
    #1 tx_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk($sformatf("tx_drain[%0d]", i), {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'(8'h10 + i)});
    end
    @(posedge clk); #1 tx_ready = 1'b0;
    @(negedge clk);
    chk("tx_empty", {31'b0, tx_valid}, 0);
    vt.push_back(vec_t'{1'b1, A_IER, 32'h02, 32'h0, 1'b0});
    run_table("thre_en");
    idle(2);
    @(negedge clk);
    chk("thre_irq", {31'b0, irq}, 1);
    vt.push_back(vec_t'{1'b0, A_IIR, 32'h0, 32'h02, 1'b0});
    run_table("thre_iir");
    @(negedge clk);
    @(negedge clk);
    chk("thre_irq_clr", {31'b0, irq}, 0);

    // RX trigger level DEPTH/2
    vt.push_back(vec_t'{1'b1, A_IER, 32'h01, 32'h0, 1'b0});
    vt.push_back(vec_t'{1'b1, A_FCR, 32'h81, 32'h0, 1'b0});
    run_table("rda_cfg");
    for (int i = 0; i < 7; i++) rx_push(8'hA0 + 8'(i), 1'b0);
    idle(2);
    @(negedge clk);
    chk("rda_below_trig", {31'b0, irq}, 0);
    rx_push(8'hA7, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("rda_irq", {31'b0, irq}, 1);
    vt.push_back(vec_t'{1'b0, A_IIR, 32'h0, 32'h04, 1'b0});
    for (int i = 0; i < 8; i++)
      vt.push_back(vec_t'{1'b0, A_DR, 32'h0, 32'hA0 + i, 1'b0});
    vt.push_back(vec_t'{1'b0, A_STAT, 32'h0, 32'h0, 1'b0});
    run_table("rda_read");
    @(negedge clk);
    @(negedge clk);
    chk("rda_irq_clr", {31'b0, irq}, 0);

    // RX overrun, LS priority, sticky clear, RXCLR
    vt.push_back(vec_t'{1'b1, A_IER, 32'h05, 32'h0, 1'b0});
    run_table("ls_cfg");
    for (int i = 0; i < 16; i++) rx_push(8'h30 + 8'(i), 1'b0);
    rx_push(8'hEE, 1'b1);
    vt.push_back(vec_t'{1'b0, A_IIR, 32'h0, 32'h06, 1'b0});
    vt.push_back(vec_t'{1'b0, A_LSR, 32'h0, 32'h63, 1'b0});
    vt.push_back(vec_t'{1'b0, A_LSR, 32'h0, 32'h61, 1'b0});
    vt.push_back(vec_t'{1'b0, A_STAT, 32'h0, 32'h10, 1'b0});
    vt.push_back(vec_t'{1'b0, A_IIR, 32'h0, 32'h04, 1'b0});
    vt.push_back(vec_t'{1'b1, A_FCR, 32'h83, 32'h0, 1'b0});
    vt.push_back(vec_t'{1'b0, A_STAT, 32'h0, 32'h0, 1'b0});
    vt.push_back(vec_t'{1'b0, A_FCR, 32'h0, 32'h81, 1'b0});
    vt.push_back(vec_t'{1'b0, A_DR, 32'h0, 32'h0, 1'b0});
    run_table("overrun");

    // FIFOs disabled: single-byte depth
    vt.push_back(vec_t'{1'b1, A_FCR, 32'h00, 32'h0, 1'b0});
    run_table("d1_cfg");
    rx_push(8'h55, 1'b0);
    rx_push(8'h66, 1'b0);
    vt.push_back(vec_t'{1'b0, A_STAT, 32'h0, 32'h1, 1'b0});
    vt.push_back(vec_t'{1'b0, A_DR, 32'h0, 32'h55, 1'b0});
    vt.push_back(vec_t'{1'b0, A_LSR, 32'h0, 32'h62, 1'b0});
    vt.push_back(vec_t'{1'b0, A_STAT, 32'h0, 32'h0, 1'b0});
    run_table("depth1");

    // Reset during the access phase aborts the transfer
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_LCR; pwdata = 32'h7F;
    @(posedge clk); #1 penable = 1'b1;
    @(negedge clk) rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst_abort.ready[%0d]", i), {31'b0, pready}, 0);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; rstn = 1'b1;
    @(negedge clk);
    chk("rst_abort.lcr", {25'b0, lcr}, 0);
    chk("rst_abort.dlr", {16'b0, dlr}, 0);
    chk("rst_abort.irq_tx", {30'b0, irq, tx_valid}, 0);
    vt.push_back(vec_t'{1'b0, A_LCR, 32'h0, 32'h0, 1'b0});
    vt.push_back(vec_t'{1'b0, A_DLR, 32'h0, 32'h0, 1'b0});
    vt.push_back(vec_t'{1'b0, A_IER, 32'h0, 32'h0, 1'b0});
    vt.push_back(vec_t'{1'b0, A_FCR, 32'h0, 32'h0, 1'b0});
    vt.push_back(vec_t'{1'b0, A_LSR, 32'h0, 32'h60, 1'b0});
    vt.push_back(vec_t'{1'b0, A_IIR, 32'h0, 32'h01, 1'b0});
    run_table("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
